// File: rtl/urv_mem_responder.sv
// urv_mem_responder
//   Behavioural memory responder for a small RISC-V core. It has one RAM of
//   2**g_addr_width 32-bit words behind two ports:
//   - an instruction port that never stalls: one registered read per cycle
//   - a data port run by an IDLE/WAIT FSM, with g_dm_wait extra wait cycles
//     on every access
//   The RAM is word-indexed with byte address bits [g_addr_width+1:2]. All
//   higher address bits alias onto the same words.
//
// Ports
//   clk_i            : clock (rising edge)
//   rst_n_i          : asynchronous active-low reset; its release is synchronised inside
//   im_addr_i        : instruction byte address
//   im_rd_i          : instruction fetch request
//   im_data_o        : fetched word (holds its value when no fetch is made)
//   im_valid_o       : im_data_o was fetched in the previous cycle
//   dm_addr_i        : data byte address
//   dm_data_s_i      : store data
//   dm_data_select_i : byte-lane enables for stores (bit n enables byte n)
//   dm_store_i       : store request pulse
//   dm_load_i        : load request pulse
//   dm_data_l_o      : load data (full word, held until the next load completes)
//   dm_load_done_o   : one-cycle load completion pulse
//   dm_store_done_o  : one-cycle store completion pulse
//   err_o            : sticky protocol-error flag (cleared only by reset)
module urv_mem_responder #(
  parameter int g_addr_width = 12,
  parameter int g_dm_wait    = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] im_addr_i,
  input  logic        im_rd_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        err_o
);

  localparam int c_depth = 2 ** g_addr_width;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  logic [1:0]              rst_sync_r;
  logic                    rst_int_n_s;
  logic [31:0]             mem_r [c_depth];
  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [3:0]              cnt_r;
  logic [g_addr_width-1:0] addr_r;
  logic [31:0]             wdata_r;
  logic [3:0]              sel_r;
  logic                    is_store_r;
  logic                    load_done_r;
  logic                    store_done_r;
  logic                    err_r;
  logic [31:0]             dm_data_l_r;
  logic                    im_valid_r;
  logic [31:0]             im_data_r;
  logic                    req_s;
  logic                    accept_s;
  logic                    access_s;
  logic                    err_set_s;
  logic                    unused_addr_bits_s;

  // The address bits outside the RAM index are intentionally ignored, which makes the addresses alias.
  assign unused_addr_bits_s = ^{im_addr_i[31:g_addr_width+2], im_addr_i[1:0],
                                dm_addr_i[31:g_addr_width+2], dm_addr_i[1:0]};

  // Reset synchroniser: assertion is asynchronous and release takes effect two edges later.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];
  assign req_s       = dm_load_i | dm_store_i;

  // Data FSM next state, request acceptance and error detection.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    access_s    = 1'b0;
    err_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          // The done cycle still belongs to the previous access, so a request made in it is refused.
          if (load_done_r | store_done_r) begin
            err_set_s = 1'b1;
          end else begin
            accept_s    = 1'b1;
            state_nxt_s = ST_WAIT;
            err_set_s   = dm_load_i & dm_store_i;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        err_set_s = req_s;
        if (cnt_r == 4'd0) begin
          access_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Data FSM state, latched request, wait counter, done pulses and error flag.
  always_ff @(posedge clk_i or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      addr_r       <= '0;
      wdata_r      <= 32'h0;
      sel_r        <= 4'h0;
      is_store_r   <= 1'b0;
      load_done_r  <= 1'b0;
      store_done_r <= 1'b0;
      err_r        <= 1'b0;
      dm_data_l_r  <= 32'h0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        addr_r     <= dm_addr_i[g_addr_width+1:2];
        wdata_r    <= dm_data_s_i;
        sel_r      <= dm_data_select_i;
        is_store_r <= dm_store_i;  // store wins when both requests are set
        cnt_r      <= 4'(g_dm_wait);
      end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      load_done_r  <= access_s & ~is_store_r;
      store_done_r <= access_s & is_store_r;
      if (access_s && !is_store_r) begin
        dm_data_l_r <= mem_r[addr_r];
      end
      err_r <= err_r | err_set_s;
    end
  end

  // RAM byte-lane write. It is not reset, and it is gated by the FSM state, so a reset prevents the write.
  always_ff @(posedge clk_i) begin
    if (access_s && is_store_r) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_r[b]) begin
          mem_r[addr_r][8*b +: 8] <= wdata_r[8*b +: 8];
        end
      end
    end
  end

  // Instruction port: a registered read every cycle, which sees the old word if a store hits the same word.
  always_ff @(posedge clk_i or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      im_valid_r <= 1'b0;
      im_data_r  <= 32'h0;
    end else begin
      im_valid_r <= im_rd_i;
      if (im_rd_i) begin
        im_data_r <= mem_r[im_addr_i[g_addr_width+1:2]];
      end
    end
  end

  assign im_data_o       = im_data_r;
  assign im_valid_o      = im_valid_r;
  assign dm_data_l_o     = dm_data_l_r;
  assign dm_load_done_o  = load_done_r;
  assign dm_store_done_o = store_done_r;
  assign err_o           = err_r;

endmodule

// File: tb/tb_urv_mem_responder.sv
// Self-checking bench for urv_mem_responder. It drives two instances:
// instance 0 uses g_dm_wait=0 and instance 1 uses g_dm_wait=3. When a load
// is issued, its expected data is pushed to a scoreboard queue. The entry is
// popped and compared when dm_load_done_o fires.
module tb_urv_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n    [2];
  logic [31:0] im_addr  [2];
  logic        im_rd    [2];
  logic [31:0] im_data  [2];
  logic        im_valid [2];
  logic [31:0] dm_addr  [2];
  logic [31:0] dm_wdata [2];
  logic [3:0]  dm_sel   [2];
  logic        dm_store [2];
  logic        dm_load  [2];
  logic [31:0] dm_rdata [2];
  logic        ld_done  [2];
  logic        st_done  [2];
  logic        err      [2];

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  urv_mem_responder #(.g_addr_width(12), .g_dm_wait(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n[0]),
    .im_addr_i(im_addr[0]), .im_rd_i(im_rd[0]), .im_data_o(im_data[0]), .im_valid_o(im_valid[0]),
    .dm_addr_i(dm_addr[0]), .dm_data_s_i(dm_wdata[0]), .dm_data_select_i(dm_sel[0]),
    .dm_store_i(dm_store[0]), .dm_load_i(dm_load[0]), .dm_data_l_o(dm_rdata[0]),
    .dm_load_done_o(ld_done[0]), .dm_store_done_o(st_done[0]), .err_o(err[0])
  );

  urv_mem_responder #(.g_addr_width(12), .g_dm_wait(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n[1]),
    .im_addr_i(im_addr[1]), .im_rd_i(im_rd[1]), .im_data_o(im_data[1]), .im_valid_o(im_valid[1]),
    .dm_addr_i(dm_addr[1]), .dm_data_s_i(dm_wdata[1]), .dm_data_select_i(dm_sel[1]),
    .dm_store_i(dm_store[1]), .dm_load_i(dm_load[1]), .dm_data_l_o(dm_rdata[1]),
    .dm_load_done_o(ld_done[1]), .dm_store_done_o(st_done[1]), .err_o(err[1])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for its done pulse, and check the latency, the kind, the load data and the pulse width.
  task automatic do_req(input int d, input bit is_st, input bit is_ld, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] sel, input logic [31:0] exp_data,
                        input int exp_lat, input string tag);
    int lat;
    if (is_ld && !is_st) exp_q.push_back(exp_data);
    dm_addr[d] = addr; dm_wdata[d] = data; dm_sel[d] = sel;
    dm_store[d] = is_st; dm_load[d] = is_ld;
    tick();
    dm_store[d] = 1'b0; dm_load[d] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (st_done[d] || ld_done[d]) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (lat != 0) begin
      check({tag, "_kind"}, {31'b0, ld_done[d]}, {31'b0, is_ld && !is_st});
      if (ld_done[d]) check({tag, "_data"}, dm_rdata[d], exp_q.pop_front());
    end
    tick();
    check({tag, "_pulse"}, {31'b0, st_done[d] | ld_done[d]}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; im_addr[d] = 32'h0; im_rd[d] = 1'b0;
      dm_addr[d] = 32'h0; dm_wdata[d] = 32'h0; dm_sel[d] = 4'h0;
      dm_store[d] = 1'b0; dm_load[d] = 1'b0;
    end
    tick(); tick(); tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_im_valid", {31'b0, im_valid[d]}, 32'h0);
      check("rst_im_data",  im_data[d], 32'h0);
      check("rst_ld_done",  {31'b0, ld_done[d]}, 32'h0);
      check("rst_st_done",  {31'b0, st_done[d]}, 32'h0);
      check("rst_err",      {31'b0, err[d]}, 32'h0);
      check("rst_dm_data",  dm_rdata[d], 32'h0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    tick(); tick(); tick();

    // Zero-wait instance: basic store and load, byte lanes, select 0, fetch aliasing and both requests at once.
    do_req(0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 1, "st_deadbeef");
    do_req(0, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 1, "ld_deadbeef");
    do_req(0, 1'b1, 1'b0, 32'h200, 32'hAAAAAAAA, 4'hF, 32'h0, 1, "st_aaaa");
    do_req(0, 1'b1, 1'b0, 32'h200, 32'h11223344, 4'b0101, 32'h0, 1, "st_lanes");
    do_req(0, 1'b0, 1'b1, 32'h200, 32'h0, 4'hF, 32'hAA22AA44, 1, "ld_lanes");
    do_req(0, 1'b1, 1'b0, 32'h200, 32'h55555555, 4'b0000, 32'h0, 1, "st_sel0");
    do_req(0, 1'b0, 1'b1, 32'h200, 32'h0, 4'hF, 32'hAA22AA44, 1, "ld_sel0");
    do_req(0, 1'b1, 1'b0, 32'h0, 32'h00000013, 4'hF, 32'h0, 1, "st_insn");
    im_addr[0] = 32'h4000; im_rd[0] = 1'b1;
    tick();
    im_rd[0] = 1'b0;
    check("fetch_valid", {31'b0, im_valid[0]}, 32'h1);
    check("fetch_data",  im_data[0], 32'h00000013);
    tick();
    check("fetch_idle_valid", {31'b0, im_valid[0]}, 32'h0);
    check("fetch_idle_hold",  im_data[0], 32'h00000013);
    do_req(0, 1'b0, 1'b1, 32'h4100, 32'h0, 4'hF, 32'hDEADBEEF, 1, "ld_alias");
    check("err0_clean", {31'b0, err[0]}, 32'h0);
    do_req(0, 1'b1, 1'b1, 32'h300, 32'h0BADF00D, 4'hF, 32'h0, 1, "both_req");
    check("err0_both", {31'b0, err[0]}, 32'h1);
    do_req(0, 1'b0, 1'b1, 32'h300, 32'h0, 4'hF, 32'h0BADF00D, 1, "ld_both");

    // Three-wait instance: latency, and a load issued during WAIT.
    do_req(1, 1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 4'hF, 32'h0, 4, "st3");
    check("err3_clean", {31'b0, err[1]}, 32'h0);
    exp_q.push_back(32'hCAFEF00D);
    dm_addr[1] = 32'h100; dm_load[1] = 1'b1;
    tick();                                   // edge N
    dm_load[1] = 1'b0;
    check("w3_n0", {31'b0, ld_done[1]}, 32'h0);
    tick();                                   // edge N+1
    check("w3_n1", {31'b0, ld_done[1]}, 32'h0);
    dm_addr[1] = 32'h200; dm_load[1] = 1'b1;
    tick();                                   // edge N+2: this load must be ignored
    dm_load[1] = 1'b0;
    check("w3_n2", {31'b0, ld_done[1]}, 32'h0);
    tick();
    check("w3_n3", {31'b0, ld_done[1]}, 32'h0);
    tick();
    check("w3_n4", {31'b0, ld_done[1]}, 32'h1);
    check("w3_data", dm_rdata[1], exp_q.pop_front());
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen = seen | ld_done[1];
    end
    check("w3_dropped", {31'b0, seen}, 32'h0);
    check("w3_err", {31'b0, err[1]}, 32'h1);

    // Eight back-to-back fetches while a store runs. The fetch at i=4 collides with the store's write.
    for (int i = 0; i < 8; i++)
      do_req(1, 1'b1, 1'b0, 32'h400 + 32'(4*i), 32'hA5000000 | 32'(i), 4'hF, 32'h0, 4, "pre");
    for (int i = 0; i < 8; i++) begin
      im_addr[1] = 32'h400 + 32'(4*i); im_rd[1] = 1'b1;
      dm_addr[1] = 32'h410; dm_wdata[1] = 32'h5EED0000; dm_sel[1] = 4'hF;
      dm_store[1] = (i == 0);
      tick();
      check("burst_valid", {31'b0, im_valid[1]}, 32'h1);
      check("burst_data",  im_data[1], 32'hA5000000 | 32'(i));
      check("burst_st_done", {31'b0, st_done[1]}, {31'b0, i == 4});
    end
    dm_store[1] = 1'b0; im_rd[1] = 1'b0;
    im_addr[1] = 32'h410; im_rd[1] = 1'b1;
    tick();
    im_rd[1] = 1'b0;
    check("rbw_new_word", im_data[1], 32'h5EED0000);
    tick();

    // Reset during a three-wait store aborts the store.
    do_req(1, 1'b1, 1'b0, 32'h600, 32'h12345678, 4'hF, 32'h0, 4, "st_pre_rst");
    dm_addr[1] = 32'h600; dm_wdata[1] = 32'hFFFFFFFF; dm_store[1] = 1'b1;
    tick();
    dm_store[1] = 1'b0;
    tick();
    rst_n[1] = 1'b0;
    #1;
    check("mid_rst_im_valid", {31'b0, im_valid[1]}, 32'h0);
    check("mid_rst_im_data",  im_data[1], 32'h0);
    check("mid_rst_ld_done",  {31'b0, ld_done[1]}, 32'h0);
    check("mid_rst_err",      {31'b0, err[1]}, 32'h0);
    check("mid_rst_dm_data",  dm_rdata[1], 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen = seen | st_done[1];
    end
    check("mid_rst_no_done", {31'b0, seen}, 32'h0);
    rst_n[1] = 1'b1;
    tick(); tick(); tick();
    do_req(1, 1'b0, 1'b1, 32'h600, 32'h0, 4'hF, 32'h12345678, 4, "ld_after_rst");
    check("err3_after_rst", {31'b0, err[1]}, 32'h0);

    // A load made in the done cycle is refused. One cycle later a load is accepted.
    dm_addr[1] = 32'h700; dm_wdata[1] = 32'h00000077; dm_sel[1] = 4'hF; dm_store[1] = 1'b1;
    tick();
    dm_store[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (st_done[1]) begin
        seen = 1'b1;
        break;
      end
    end
    check("dc_store_done", {31'b0, seen}, 32'h1);
    dm_load[1] = 1'b1;
    tick();
    dm_load[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen = seen | ld_done[1];
    end
    check("dc_load_dropped", {31'b0, seen}, 32'h0);
    check("dc_err", {31'b0, err[1]}, 32'h1);
    do_req(1, 1'b0, 1'b1, 32'h700, 32'h0, 4'hF, 32'h00000077, 4, "ld_after_dc");

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/urv_mem_responder.md
URV_MEM_RESPONDER -- requirements
Module: urv_mem_responder

Interface
REQ-001 SHALL have parameter g_addr_width, default 12, which sets the word-address width (RAM depth 2^g_addr_width words of 32 bits).
REQ-002 SHALL have parameter g_dm_wait, default 0, range 0..15: extra wait cycles added to every data access.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port im_addr_i, input, 32 bits: instruction byte address.
REQ-006 SHALL have port im_rd_i, input, 1 bit: instruction fetch request.
REQ-007 SHALL have port im_data_o, output, 32 bits: instruction word.
REQ-008 SHALL have port im_valid_o, output, 1 bit: im_data_o valid.
REQ-009 SHALL have port dm_addr_i, input, 32 bits: data byte address.
REQ-010 SHALL have port dm_data_s_i, input, 32 bits: store data.
REQ-011 SHALL have port dm_data_select_i, input, 4 bits: byte-lane enables; bit n enables byte n.
REQ-012 SHALL have port dm_store_i, input, 1 bit: one-cycle store request pulse.
REQ-013 SHALL have port dm_load_i, input, 1 bit: one-cycle load request pulse.
REQ-014 SHALL have port dm_data_l_o, output, 32 bits: load data.
REQ-015 SHALL have port dm_load_done_o, output, 1 bit: one-cycle load completion pulse.
REQ-016 SHALL have port dm_store_done_o, output, 1 bit: one-cycle store completion pulse.
REQ-017 SHALL have port err_o, output, 1 bit: sticky protocol-error flag.

Function
REQ-018 SHALL index the RAM with address bits [g_addr_width+1:2] only; upper bits are ignored and addresses alias; bits [1:0] are ignored.
REQ-019 Instruction port: when im_rd_i=1 at edge N, SHALL drive im_valid_o=1 in cycle N+1 with im_data_o = RAM[im_addr_i] as sampled at edge N.
REQ-020 When im_rd_i=0, im_valid_o SHALL be 0 in the next cycle, and im_data_o SHALL hold its last value.
REQ-021 The instruction port SHALL be independent of the data FSM and SHALL never stall.
REQ-022 Data FSM SHALL have states IDLE and WAIT.
REQ-023 In IDLE, a request (dm_load_i or dm_store_i) SHALL latch the address, data, select and kind, load wait counter = g_dm_wait, and go to WAIT.
REQ-024 In WAIT, the counter SHALL decrement each cycle while nonzero.
REQ-025 On the WAIT cycle with counter == 0, the block SHALL perform the access, pulse the matching done for exactly one cycle (registered), and return to IDLE.
REQ-026 Data latency, request edge to done high: 1 + g_dm_wait cycles; g_dm_wait=0 gives done in the cycle after the request.
REQ-027 Store: only lanes with dm_data_select_i[n]=1 SHALL be written; a select of 4'b0000 writes nothing but still completes.
REQ-028 Load: dm_data_l_o SHALL be the full 32-bit word, valid in the done cycle and held until the next load completes; the block does no lane extraction or sign extension.
REQ-029 dm_load_i and dm_store_i both high in the same cycle: the store SHALL be served, the load dropped, and err_o set.
REQ-030 A request arriving while in WAIT, or in the done cycle before IDLE is re-entered, SHALL be ignored and SHALL set err_o.
REQ-031 A request in the cycle right after done (FSM back in IDLE) SHALL be accepted normally.
REQ-032 The instruction port SHALL return the old word when it reads an address in the same cycle that a data store writes it (read-before-write); this applies on any port collision.
REQ-033 err_o SHALL be cleared only by reset.

Reset
REQ-034 While rst_n_i=0, the following SHALL be held at 0 asynchronously: im_valid_o, dm_load_done_o, dm_store_done_o, err_o, the FSM (IDLE) and the wait counter.
REQ-035 im_data_o and dm_data_l_o SHALL reset to 32'h0.
REQ-036 RAM contents SHALL NOT be reset.
REQ-037 Reset asserted mid-access SHALL abort the access: no done pulse, and no partial write if reset occurs before the access cycle.
REQ-038 Reset deassertion SHALL be synchronised internally; the first request is accepted no earlier than 2 cycles after rst_n_i rises.

Verification
REQ-039 g_dm_wait=0: store 32'hDEADBEEF to 0x100 with select 4'hF, then load 0x100 -> dm_store_done_o 1 cycle after the store; dm_load_done_o 1 cycle after the load with dm_data_l_o=32'hDEADBEEF.
REQ-040 Store 32'h11223344 with select 4'b0101 over a word holding 32'hAAAAAAAA, then load -> 32'hAA22AA44.
REQ-041 g_dm_wait=3: load issued at edge N -> dm_load_done_o high only in cycle N+4; a second load at N+2 is ignored and err_o=1.
REQ-042 With g_addr_width=12, fetch 0x4000 after storing 32'h00000013 to 0x0 -> im_valid_o=1 and im_data_o=32'h00000013 one cycle later.
REQ-043 Continuous im_rd_i over 8 cycles while stores run -> 8 back-to-back valid words, with no effect on data-port timing.
REQ-044 Pulse rst_n_i low during a g_dm_wait=3 store -> no done pulse, target word unchanged, all outputs 0.
